lfsr_128bit_checker: RTL

- Receive side of the 128-bit programmable-tap LFSR pattern source.
- Consumes the serial bit stream the generator shifts in (one new bit per enabled cycle) and self-synchronises its own 128-bit state.
- After synchronising, predicts each following bit and flags mismatches.
- Used for PRBS link and self-test checking and for tap-configuration validation next to the LFSR generator.

---
 rtl/lfsr_128bit_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_128bit_checker.sv
// Receive-side checker for the 128-bit programmable-tap LFSR pattern source.
// Optional seed preload path is enabled by defining LFSR_CHK_SEED_LOAD_EN.
module lfsr_128bit_checker #(
    parameter int VERIFY_LEN = 32,
    parameter int ERR_THRESH = 8,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 data_i,
    input  logic [41:0]          shift_idx_i,
    input  logic                 resync_i,
    input  logic                 clr_cnt_i,
`ifdef LFSR_CHK_SEED_LOAD_EN
    input  logic                 seed_load_i,
    input  logic [127:0]         seed_i,
`endif
    output logic [1:0]           state_o,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [127:0]         chk_state_o
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        VERIFY  = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    localparam logic [7:0] VERIFY_LAST = 8'(VERIFY_LEN - 1);
    localparam logic [7:0] ERR_LIMIT   = 8'(ERR_THRESH);

    chk_state_e           state_q, state_d;
    logic [127:0]         shadow_q, shadow_d;
    logic [6:0]           fill_q, fill_d;
    logic [7:0]           verify_q, verify_d;
    logic [6:0]           win_cnt_q, win_cnt_d;
    logic [7:0]           win_err_q, win_err_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 locked_q;
    logic                 tap_xor;
    logic                 pred;
    logic                 lock_miss;

    always_comb begin
        tap_xor = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tap_xor = tap_xor ^ shadow_q[shift_idx_i[i*7 +: 7]];
        end
    end

    assign pred = ~tap_xor;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        fill_d    = fill_q;
        verify_d  = verify_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_d     = 1'b0;
        lock_miss = 1'b0;

        if (resync_i) begin
            state_d  = ACQUIRE;
            fill_d   = 7'd0;
            verify_d = 8'd0;
`ifdef LFSR_CHK_SEED_LOAD_EN
        end else if (seed_load_i) begin
            state_d   = LOCKED;
            shadow_d  = seed_i;
            fill_d    = 7'd0;
            verify_d  = 8'd0;
            win_cnt_d = 7'd0;
            win_err_d = 8'd0;
`endif
        end else if (en_i) begin
            case (state_q)
                ACQUIRE: begin
                    shadow_d = {shadow_q[126:0], data_i};
                    fill_d   = fill_q + 7'd1;
                    if (fill_q == 7'd127) begin
                        state_d  = VERIFY;
                        verify_d = 8'd0;
                    end
                end
                VERIFY: begin
                    shadow_d = {shadow_q[126:0], data_i};
                    if (data_i == pred) begin
                        if (verify_q == VERIFY_LAST) begin
                            state_d   = LOCKED;
                            verify_d  = 8'd0;
                            win_cnt_d = 7'd0;
                            win_err_d = 8'd0;
                        end else begin
                            verify_d = verify_q + 8'd1;
                        end
                    end else begin
                        verify_d = 8'd0;
                    end
                end
                LOCKED: begin
                    // Locked shadow free-runs on its own prediction so a line error cannot corrupt it.
                    lock_miss = (data_i != pred);
                    err_d     = lock_miss;
                    win_cnt_d = win_cnt_q + 7'd1;
                    win_err_d = ((win_cnt_q == 7'd127) ? 8'd0 : win_err_q) + {7'd0, lock_miss};
                    if (lock_miss && (win_err_d == ERR_LIMIT)) begin
                        state_d = ACQUIRE;
                        fill_d  = 7'd0;
                    end else begin
                        shadow_d = {shadow_q[126:0], pred};
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    fill_d  = 7'd0;
                end
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end else if (lock_miss && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ACQUIRE;
            shadow_q  <= '0;
            fill_q    <= '0;
            verify_q  <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            fill_q    <= fill_d;
            verify_q  <= verify_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= (state_d == LOCKED);
        end
    end

    assign state_o     = state_q;
    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign chk_state_o = shadow_q;

endmodule
